mm_burst_split_bridge: RTL and testbench

- Avalon-MM pipeline bridge between a bursting slave port (s0) and a single-beat master port (m0).
- Successor to the sub-CPU mm_bridge master: the m0 side keeps burstcount 1, but data width, address width and s0 burst width are parametrised.
- s0 read/write bursts are split into incrementing single-beat m0 transfers.
- Outstanding read beats are capped by a credit counter so downstream slaves are never over-subscribed.

---
 rtl/mm_burst_split_bridge.sv | 180 ++++++++++++++++++
 tb/tb_mm_burst_split_bridge.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_burst_split_bridge.sv
// Avalon-MM bridge: splits bursting s0 reads/writes into single-beat m0 transfers,
// with a credit counter bounding outstanding read beats on m0.
module mm_burst_split_bridge #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned BURST_WIDTH = 4,
    parameter int unsigned MAX_PENDING = 8
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [ADDR_WIDTH-1:0]   s0_address,
    input  logic [BURST_WIDTH-1:0]  s0_burstcount,
    input  logic                    s0_read,
    input  logic                    s0_write,
    input  logic [DATA_WIDTH-1:0]   s0_writedata,
    input  logic [DATA_WIDTH/8-1:0] s0_byteenable,
    input  logic                    s0_debugaccess,
    output logic                    s0_waitrequest,
    output logic [DATA_WIDTH-1:0]   s0_readdata,
    output logic                    s0_readdatavalid,
    input  logic                    m0_waitrequest,
    input  logic [DATA_WIDTH-1:0]   m0_readdata,
    input  logic                    m0_readdatavalid,
    output logic                    m0_burstcount,
    output logic [DATA_WIDTH-1:0]   m0_writedata,
    output logic [ADDR_WIDTH-1:0]   m0_address,
    output logic                    m0_write,
    output logic                    m0_read,
    output logic [DATA_WIDTH/8-1:0] m0_byteenable,
    output logic                    m0_debugaccess
);

    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
    localparam int unsigned PEND_WIDTH = $clog2(MAX_PENDING + 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(BE_WIDTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [BURST_WIDTH-1:0]  beats_q, beats_d;
    logic [PEND_WIDTH-1:0]   pending_q, pending_d;
    logic [PEND_WIDTH-1:0]   pend_avail;
    logic [BURST_WIDTH-1:0]  bc;
    logic [BURST_WIDTH-1:0]  rd_add;
    logic                    slot_free;
    logic                    rd_credit_ok;
    logic                    load_rd, load_wr;
    logic                    wait_c;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   data_d;
    logic [BE_WIDTH-1:0]     be_d;
    logic                    dbg_d;

    assign m0_burstcount = 1'b1;
    assign slot_free     = !(m0_read || m0_write) || !m0_waitrequest;
    assign bc            = (s0_burstcount == '0) ? BURST_WIDTH'(1) : s0_burstcount;
    // A response retiring this cycle frees its credit for a same-cycle accept.
    assign pend_avail    = (m0_readdatavalid && (pending_q != '0)) ?
                           (pending_q - PEND_WIDTH'(1)) : pending_q;
    assign rd_credit_ok  = (32'(pend_avail) + 32'(bc)) <= MAX_PENDING;
    assign s0_waitrequest = reset_reset || wait_c;

    // Next-state, slot load decisions and s0 stall
    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        load_rd = 1'b0;
        load_wr = 1'b0;
        wait_c  = 1'b0;
        rd_add  = '0;
        addr_d  = m0_address;
        data_d  = m0_writedata;
        be_d    = m0_byteenable;
        dbg_d   = m0_debugaccess;
        case (state_q)
            IDLE: begin
                if (s0_read) begin
                    wait_c = !(slot_free && rd_credit_ok);
                    if (slot_free && rd_credit_ok) begin
                        load_rd = 1'b1;
                        addr_d  = s0_address;
                        be_d    = s0_byteenable;
                        dbg_d   = s0_debugaccess;
                        beats_d = bc - BURST_WIDTH'(1);
                        rd_add  = bc;
                        if (bc != BURST_WIDTH'(1)) begin
                            state_d = RD_BURST;
                        end
                    end
                end else if (s0_write) begin
                    wait_c = !slot_free;
                    if (slot_free) begin
                        load_wr = 1'b1;
                        addr_d  = s0_address;
                        data_d  = s0_writedata;
                        be_d    = s0_byteenable;
                        dbg_d   = s0_debugaccess;
                        beats_d = bc - BURST_WIDTH'(1);
                        if (bc != BURST_WIDTH'(1)) begin
                            state_d = WR_BURST;
                        end
                    end
                end
            end
            RD_BURST: begin
                wait_c = 1'b1;
                if (slot_free) begin
                    load_rd = 1'b1;
                    addr_d  = m0_address + BEAT_BYTES;
                    beats_d = beats_q - BURST_WIDTH'(1);
                    if (beats_q == BURST_WIDTH'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            WR_BURST: begin
                wait_c = !slot_free;
                if (s0_write && slot_free) begin
                    load_wr = 1'b1;
                    addr_d  = m0_address + BEAT_BYTES;
                    data_d  = s0_writedata;
                    be_d    = s0_byteenable;
                    dbg_d   = s0_debugaccess;
                    beats_d = beats_q - BURST_WIDTH'(1);
                    if (beats_q == BURST_WIDTH'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        pending_d = PEND_WIDTH'(32'(pend_avail) + 32'(rd_add));
    end

    // State register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command slot, burst/credit counters and registered response path
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            beats_q          <= '0;
            pending_q        <= '0;
            m0_read          <= 1'b0;
            m0_write         <= 1'b0;
            m0_address       <= '0;
            m0_writedata     <= '0;
            m0_byteenable    <= '0;
            m0_debugaccess   <= 1'b0;
            s0_readdatavalid <= 1'b0;
            s0_readdata      <= '0;
        end else begin
            beats_q          <= beats_d;
            pending_q        <= pending_d;
            s0_readdatavalid <= m0_readdatavalid;
            s0_readdata      <= m0_readdata;
            if (load_rd || load_wr) begin
                m0_read        <= load_rd;
                m0_write       <= load_wr;
                m0_address     <= addr_d;
                m0_writedata   <= data_d;
                m0_byteenable  <= be_d;
                m0_debugaccess <= dbg_d;
            end else if (slot_free) begin
                m0_read  <= 1'b0;
                m0_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mm_burst_split_bridge.sv
// Directed bench for mm_burst_split_bridge with a beat-list scoreboard and response-delay model.
module tb_mm_burst_split_bridge;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [9:0]  s0_address;
    logic [3:0]  s0_burstcount;
    logic        s0_read, s0_write;
    logic [31:0] s0_writedata;
    logic [3:0]  s0_byteenable;
    logic        s0_debugaccess;
    logic        s0_waitrequest;
    logic [31:0] s0_readdata;
    logic        s0_readdatavalid;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;
    logic        m0_burstcount;
    logic [31:0] m0_writedata;
    logic [9:0]  m0_address;
    logic        m0_write, m0_read;
    logic [3:0]  m0_byteenable;
    logic        m0_debugaccess;

    always #5 clk_clk = ~clk_clk;

    mm_burst_split_bridge #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .BURST_WIDTH(4), .MAX_PENDING(8)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .s0_address(s0_address), .s0_burstcount(s0_burstcount),
        .s0_read(s0_read), .s0_write(s0_write),
        .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
        .s0_debugaccess(s0_debugaccess), .s0_waitrequest(s0_waitrequest),
        .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_burstcount(m0_burstcount),
        .m0_writedata(m0_writedata), .m0_address(m0_address),
        .m0_write(m0_write), .m0_read(m0_read),
        .m0_byteenable(m0_byteenable), .m0_debugaccess(m0_debugaccess)
    );

    typedef struct {
        logic [9:0]  addr;
        logic        wr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        dbg;
    } beat_t;

    beat_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int n_writes = 0;

    // model state for the 1-cycle response path and the m0 hold rule
    logic        exp_rv = 1'b0;
    logic [31:0] exp_rd = '0;
    logic        prev_stall = 1'b0;
    logic        p_rd, p_wr;
    logic [9:0]  p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_be;
    beat_t       e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_clk);
        #1;
    endtask

    function automatic void push_reads(input logic [9:0] a, input logic [3:0] bc, input logic dbg);
        int n = (bc == 4'd0) ? 1 : int'(bc);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: 10'(a + 10'(4 * i)), wr: 1'b0, data: '0, be: '0, dbg: dbg});
        end
    endfunction

    task automatic send_resp(input logic [31:0] d);
        m0_readdatavalid = 1'b1;
        m0_readdata      = d;
        tick();
        m0_readdatavalid = 1'b0;
    endtask

    // Present a read until accepted (bounded), record its beats, then drop it.
    task automatic do_read(input logic [9:0] a, input logic [3:0] bc, input logic dbg);
        logic ok = 1'b0;
        s0_read = 1'b1; s0_address = a; s0_burstcount = bc;
        s0_debugaccess = dbg; s0_byteenable = 4'hF;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_clk);
            if (!s0_waitrequest) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("read_accept", 64'(ok), 64'h1);
        if (ok) push_reads(a, bc, dbg);
        tick();
        s0_read = 1'b0; s0_debugaccess = 1'b0;
    endtask

    // Write burst: beat i carries base+i and byteenable be_pat[4i+:4].
    task automatic do_write(input logic [9:0] a, input logic [3:0] bc,
                            input logic [31:0] base, input logic [31:0] be_pat);
        int n = (bc == 4'd0) ? 1 : int'(bc);
        for (int i = 0; i < n; i++) begin
            logic ok = 1'b0;
            s0_write = 1'b1; s0_address = a; s0_burstcount = bc;
            s0_writedata = base + 32'(i); s0_byteenable = be_pat[4*i +: 4];
            for (int k = 0; k < 50; k++) begin
                @(negedge clk_clk);
                if (!s0_waitrequest) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            chk("write_accept", 64'(ok), 64'h1);
            if (ok) exp_q.push_back('{addr: 10'(a + 10'(4 * i)), wr: 1'b1,
                                      data: base + 32'(i), be: be_pat[4*i +: 4], dbg: 1'b0});
            tick();
        end
        s0_write = 1'b0;
    endtask

    // Every cycle: completed m0 beats against the scoreboard, hold rule, response delay.
    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            if (prev_stall) begin
                chk("hold_read", 64'(m0_read), 64'(p_rd));
                chk("hold_write", 64'(m0_write), 64'(p_wr));
                chk("hold_addr", 64'(m0_address), 64'(p_addr));
                chk("hold_data", 64'(m0_writedata), 64'(p_data));
                chk("hold_be", 64'(m0_byteenable), 64'(p_be));
            end
            if ((m0_read || m0_write) && !m0_waitrequest) begin
                chk("beat_expected", 64'(exp_q.size() != 0), 64'h1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat_addr", 64'(m0_address), 64'(e.addr));
                    chk("beat_write", 64'(m0_write), 64'(e.wr));
                    chk("beat_read", 64'(m0_read), 64'(!e.wr));
                    chk("beat_dbg", 64'(m0_debugaccess), 64'(e.dbg));
                    if (e.wr) begin
                        chk("beat_wdata", 64'(m0_writedata), 64'(e.data));
                        chk("beat_be", 64'(m0_byteenable), 64'(e.be));
                    end
                end
                if (m0_write) n_writes++;
            end
        end
        chk("s0_rdv", 64'(s0_readdatavalid), 64'(exp_rv));
        if (exp_rv) chk("s0_rdata", 64'(s0_readdata), 64'(exp_rd));
        chk("m0_burstcount", 64'(m0_burstcount), 64'h1);
        exp_rv     = m0_readdatavalid && !reset_reset;
        exp_rd     = m0_readdata;
        prev_stall = !reset_reset && (m0_read || m0_write) && m0_waitrequest;
        p_rd = m0_read; p_wr = m0_write; p_addr = m0_address;
        p_data = m0_writedata; p_be = m0_byteenable;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int cnt;
        reset_reset = 1'b1;
        s0_address = '0; s0_burstcount = '0; s0_read = 1'b0; s0_write = 1'b0;
        s0_writedata = '0; s0_byteenable = '0; s0_debugaccess = 1'b0;
        m0_waitrequest = 1'b0; m0_readdata = '0; m0_readdatavalid = 1'b0;
        repeat (3) tick();
        @(negedge clk_clk);
        chk("rst_wait", 64'(s0_waitrequest), 64'h1);
        chk("rst_m0_read", 64'(m0_read), 64'h0);
        chk("rst_m0_write", 64'(m0_write), 64'h0);
        chk("rst_m0_addr", 64'(m0_address), 64'h0);
        chk("rst_s0_rdv", 64'(s0_readdatavalid), 64'h0);
        tick();
        reset_reset = 1'b0;
        @(negedge clk_clk);
        chk("idle_wait", 64'(s0_waitrequest), 64'h0);

        // single read and its response
        tick();
        do_read(10'h010, 4'd1, 1'b0);
        @(negedge clk_clk);
        chk("t1_m0_read", 64'(m0_read), 64'h1);
        chk("t1_m0_addr", 64'(m0_address), 64'h010);
        tick();
        m0_readdatavalid = 1'b1; m0_readdata = 32'hDEADBEEF;
        tick();
        m0_readdatavalid = 1'b0;
        @(negedge clk_clk);
        chk("t1_s0_rdv", 64'(s0_readdatavalid), 64'h1);
        chk("t1_s0_rdata", 64'(s0_readdata), 64'hDEADBEEF);

        // bc=4 read wrapping the top of the address space
        tick();
        do_read(10'h3F8, 4'd4, 1'b1);
        @(negedge clk_clk);
        chk("t2_addr0", 64'(m0_address), 64'h3F8);
        chk("t2_dbg", 64'(m0_debugaccess), 64'h1);
        chk("t2_wait0", 64'(s0_waitrequest), 64'h1);
        tick(); @(negedge clk_clk);
        chk("t2_addr1", 64'(m0_address), 64'h3FC);
        chk("t2_wait1", 64'(s0_waitrequest), 64'h1);
        tick(); @(negedge clk_clk);
        chk("t2_addr2", 64'(m0_address), 64'h000);
        chk("t2_wait2", 64'(s0_waitrequest), 64'h1);
        tick(); @(negedge clk_clk);
        chk("t2_addr3", 64'(m0_address), 64'h004);
        chk("t2_wait3", 64'(s0_waitrequest), 64'h0);
        tick();
        for (int i = 0; i < 4; i++) send_resp(32'h1000_0000 + 32'(i));

        // bc=3 write with a 2-cycle m0 stall on beat 1
        wr0 = n_writes;
        fork
            do_write(10'h020, 4'd3, 32'hA000_0000, 32'h0000_0C3F);
            begin
                for (int k = 0; k < 40; k++) begin
                    tick();
                    if (m0_write && (m0_address == 10'h024)) begin
                        m0_waitrequest = 1'b1;
                        @(negedge clk_clk);
                        chk("t3_stall_wait", 64'(s0_waitrequest), 64'h1);
                        chk("t3_stall_data", 64'(m0_writedata), 64'hA000_0001);
                        tick(); tick();
                        m0_waitrequest = 1'b0;
                        break;
                    end
                end
            end
        join
        repeat (3) tick();
        chk("t3_write_count", 64'(n_writes - wr0), 64'h3);

        // credit limit: 4+4 outstanding blocks a further read until one response retires
        do_read(10'h100, 4'd4, 1'b0);
        do_read(10'h200, 4'd4, 1'b0);
        s0_read = 1'b1; s0_address = 10'h300; s0_burstcount = 4'd1;
        repeat (5) tick();
        @(negedge clk_clk);
        chk("t4_blocked", 64'(s0_waitrequest), 64'h1);
        tick();
        m0_readdatavalid = 1'b1; m0_readdata = 32'h0000_C0DE;
        @(negedge clk_clk);
        chk("t4_release", 64'(s0_waitrequest), 64'h0);
        push_reads(10'h300, 4'd1, 1'b0);
        tick();
        s0_read = 1'b0; m0_readdatavalid = 1'b0;
        for (int i = 0; i < 8; i++) send_resp(32'h2000_0000 + 32'(i));

        // read and write together: read first, write on the next slot
        tick();
        s0_read = 1'b1; s0_write = 1'b1; s0_address = 10'h040; s0_burstcount = 4'd1;
        s0_writedata = 32'h1234_5678; s0_byteenable = 4'hF;
        @(negedge clk_clk);
        chk("t5_wait", 64'(s0_waitrequest), 64'h0);
        push_reads(10'h040, 4'd1, 1'b0);
        tick();
        s0_read = 1'b0; s0_address = 10'h080;
        @(negedge clk_clk);
        chk("t5_m0_read", 64'(m0_read), 64'h1);
        chk("t5_m0_write", 64'(m0_write), 64'h0);
        chk("t5_addr", 64'(m0_address), 64'h040);
        chk("t5_wr_wait", 64'(s0_waitrequest), 64'h0);
        exp_q.push_back('{addr: 10'h080, wr: 1'b1, data: 32'h1234_5678, be: 4'hF, dbg: 1'b0});
        tick();
        s0_write = 1'b0;
        @(negedge clk_clk);
        chk("t5_m0_write2", 64'(m0_write), 64'h1);
        chk("t5_addr2", 64'(m0_address), 64'h080);
        tick();
        send_resp(32'h5555_AAAA);

        // reset during beat 2 of a bc=8 read
        tick();
        do_read(10'h000, 4'd8, 1'b0);
        tick(); tick();
        reset_reset = 1'b1;
        m0_readdatavalid = 1'b1; m0_readdata = 32'h0000_0BAD;
        exp_q.delete();
        @(negedge clk_clk);
        chk("t6_beat2_addr", 64'(m0_address), 64'h008);
        tick();
        m0_readdatavalid = 1'b0;
        @(negedge clk_clk);
        chk("t6_m0_read", 64'(m0_read), 64'h0);
        chk("t6_m0_write", 64'(m0_write), 64'h0);
        chk("t6_m0_addr", 64'(m0_address), 64'h0);
        chk("t6_m0_wdata", 64'(m0_writedata), 64'h0);
        chk("t6_m0_be", 64'(m0_byteenable), 64'h0);
        chk("t6_m0_dbg", 64'(m0_debugaccess), 64'h0);
        chk("t6_s0_rdv", 64'(s0_readdatavalid), 64'h0);
        chk("t6_s0_rdata", 64'(s0_readdata), 64'h0);
        chk("t6_wait", 64'(s0_waitrequest), 64'h1);
        tick();
        reset_reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_clk);
            if (m0_read) cnt++;
        end
        chk("t6_no_beats", 64'(cnt), 64'h0);
        tick();
        do_read(10'h010, 4'd1, 1'b1);
        send_resp(32'h0123_4567);
        @(negedge clk_clk);
        chk("t6_post_rdata", 64'(s0_readdata), 64'h0123_4567);
        tick();
        do_read(10'h000, 4'd8, 1'b0);
        for (int i = 0; i < 8; i++) send_resp(32'h3000_0000 + 32'(i));
        repeat (4) tick();
        chk("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
